issue_queue: RTL

- Sits directly downstream of the rename stage and upstream of the functional units.
- Accepts renamed instructions, tracks physical-register readiness in a busy table, and wakes operands on writeback.
- Selects the oldest ready instruction whose functional unit is free; issues at most one per cycle.
- Flushed on a committed mispredict, in step with the rename roll-back.

---
 rtl/issue_queue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// Collapsing issue queue with busy-table wakeup and oldest-ready select.
// Optional same-cycle rename-to-issue bypass: define IQ_BYPASS_EN.

package issue_queue_pkg;
  parameter int unsigned NumPhysReg = 128;
  parameter int unsigned NumFu      = 4;
  parameter int unsigned PregW      = $clog2(NumPhysReg);
  parameter int unsigned FuW        = $clog2(NumFu);
  parameter int unsigned RobW       = 6;
  parameter int unsigned SbW        = 4;
  parameter int unsigned BrW        = 4;

  typedef struct packed {
    logic             is_wfs;
    logic [RobW-1:0]  rob_dest;
    logic [SbW-1:0]   sb_dest;
    logic [BrW-1:0]   branch_speculation;
    logic [FuW-1:0]   func_unit;
    logic             w_v;
    logic [PregW-1:0] dest_id;
    logic [PregW-1:0] source_1;
    logic [31:0]      source2_imm;
    logic             imm;
  } renamed_instruction_t;

  localparam int unsigned RENAMED_INSTRUCTION_WIDTH = $bits(renamed_instruction_t);
endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned IQ_ENTRY     = 8,
  parameter int unsigned NUM_PHYS_REG = NumPhysReg,
  parameter int unsigned NUM_FU       = NumFu,
  parameter int unsigned PREG_W       = $clog2(NUM_PHYS_REG)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  renamed_instruction_t renamed_i,
  input  logic                 renamed_v_i,
  output logic                 issue_rename_ready_o,
  output renamed_instruction_t issue_o,
  output logic                 issue_v_o,
  input  logic [NUM_FU-1:0]    fu_ready_i,
  input  logic                 wb_v_i,
  input  logic [PREG_W-1:0]    wb_preg_i,
  input  logic                 flush_i
);

  localparam int unsigned CntW = $clog2(IQ_ENTRY) + 1;
  localparam int unsigned IdxW = $clog2(IQ_ENTRY);

  renamed_instruction_t    entry_q [IQ_ENTRY];
  renamed_instruction_t    entry_d [IQ_ENTRY];
  logic [IQ_ENTRY-1:0]     s1_rdy_q, s1_rdy_d;
  logic [IQ_ENTRY-1:0]     s2_rdy_q, s2_rdy_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [NUM_PHYS_REG-1:0] busy_q, busy_d;

  logic                    run;
  logic                    ins_s1, ins_s2;
  logic [IQ_ENTRY-1:0]     cand;
  logic                    any_cand;
  logic [IdxW-1:0]         sel_idx;
  logic                    found;
  logic                    q_issue;
  logic                    accept;
  logic                    bypass;
  logic                    enq;
  logic [CntW-1:0]         ins_idx;
  logic [PREG_W-1:0]       ins_src2;

  // Readiness of the incoming instruction, including a same-cycle writeback.
  always_comb begin
    ins_src2 = renamed_i.source2_imm[PREG_W-1:0];
    ins_s1   = !busy_q[renamed_i.source_1] || (wb_v_i && (wb_preg_i == renamed_i.source_1));
    ins_s2   = renamed_i.imm || !busy_q[ins_src2] || (wb_v_i && (wb_preg_i == ins_src2));
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < IQ_ENTRY; i++) begin
      cand[i] = (CntW'(i) < count_q) && s1_rdy_q[i] && s2_rdy_q[i] &&
                fu_ready_i[entry_q[i].func_unit];
    end
    any_cand = |cand;
  end

  // Lowest index is oldest.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < IQ_ENTRY; i++) begin
      if (cand[i] && !found) begin
        found   = 1'b1;
        sel_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    run                  = reset_n_i && !flush_i;
    q_issue              = run && any_cand;
    issue_rename_ready_o = run && (count_q != CntW'(IQ_ENTRY));
    accept               = renamed_v_i && issue_rename_ready_o;
`ifdef IQ_BYPASS_EN
    bypass = accept && !any_cand && ins_s1 && ins_s2 && fu_ready_i[renamed_i.func_unit];
`else
    bypass = 1'b0;
`endif
    enq       = accept && !bypass;
    issue_v_o = q_issue || bypass;
    issue_o   = bypass ? renamed_i : entry_q[sel_idx];
  end

  always_comb begin
    int unsigned src;
    ins_idx = count_q - CntW'(q_issue);
    for (int i = 0; i < IQ_ENTRY; i++) begin
      src = (q_issue && (CntW'(i) >= CntW'(sel_idx))) ? i + 1 : i;
      if (src < IQ_ENTRY) begin
        entry_d[i]  = entry_q[src];
        s1_rdy_d[i] = s1_rdy_q[src] ||
                      (wb_v_i && (entry_q[src].source_1 == wb_preg_i));
        s2_rdy_d[i] = s2_rdy_q[src] ||
                      (wb_v_i && !entry_q[src].imm &&
                       (entry_q[src].source2_imm[PREG_W-1:0] == wb_preg_i));
      end else begin
        entry_d[i]  = entry_q[i];
        s1_rdy_d[i] = 1'b0;
        s2_rdy_d[i] = 1'b0;
      end
    end
    if (enq) begin
      entry_d[ins_idx[IdxW-1:0]]  = renamed_i;
      s1_rdy_d[ins_idx[IdxW-1:0]] = ins_s1;
      s2_rdy_d[ins_idx[IdxW-1:0]] = ins_s2;
    end
    count_d = count_q + CntW'(enq) - CntW'(q_issue);

    // Clear before set so a same-cycle reallocation of the register stays busy.
    busy_d = busy_q;
    if (wb_v_i) busy_d[wb_preg_i] = 1'b0;
    if (accept && renamed_i.w_v) busy_d[renamed_i.dest_id] = 1'b1;

    if (flush_i) begin
      count_d = '0;
      busy_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q  <= '0;
      busy_q   <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
    end else begin
      count_q  <= count_d;
      busy_q   <= busy_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
    end
  end

  // Payload needs no reset; validity comes from count_q.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < IQ_ENTRY; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

endmodule
